sdes_block_ctrl: RTL and testbench
==================================

Name: sdes_block_ctrl

Overview:
- Iterative S-DES encrypt/decrypt engine built around a single time-multiplexed feistel_round instance.
- feistel_round: 8-bit data, 8-bit subkey; output {L ^ F(R,K), R}.
- Owns the key schedule (P10, LS-1/LS-2, P8), the initial/inverse permutations, the half swap and subkey ordering.
- Presents valid/ready handshakes on both sides; sits between the board I/O wrapper and the result display/UART path.

Parameters:
- KEY_CACHE, 1, when 1 a block whose key equals the last scheduled key skips the KEY state; when 0 KEY is always run.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request carries valid data/key/mode.
- in_ready  out  1  engine can accept a request this cycle.
- in_data  in  8  plaintext or ciphertext, bit 7 = S-DES bit 1.
- in_key  in  10  10-bit key, bit 9 = S-DES bit 1.
- in_decrypt  in  1  0 = encrypt (K1 then K2), 1 = decrypt (K2 then K1).
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  consumer takes the result.
- out_data  out  8  result after IP^-1.
- busy  out  1  high in any state other than IDLE.
- blk_count  out  CNT_W  number of results handed off (out_valid & out_ready); wraps to 0.

Behaviour:
- Permutations (1 = MSB): P10 = 3 5 2 7 4 10 1 9 8 6; P8 = 6 3 7 4 8 5 10 9; IP = 2 6 3 1 4 8 5 7; IP^-1 = 4 1 3 5 7 2 8 6.
- Key schedule: K1 = P8(LS-1 of each 5-bit half of P10(key)); K2 = P8(LS-2 applied to those shifted halves).
- FSM states: IDLE, KEY, R1, R2, DONE.
- Accept: in_valid & in_ready.
- On accept:
  - Register IP(in_data) in the data register, and in_key and in_decrypt in their registers.
  - Go to KEY if KEY_CACHE = 0, cache_vld = 0, or in_key differs from the cached key; otherwise go to R1.
- KEY (1 cycle): load K1 and K2 registers, load cached key, set cache_vld; -> R1.
- R1: data <= swap halves of feistel_round(data, decrypt ? K2 : K1); -> R2.
- R2: out_data <= IP^-1(feistel_round(data, decrypt ? K1 : K2)); out_valid <= 1; -> DONE.
- Latency, accept edge E0:
  - With KEY: out_valid first high after edge E3.
  - Cache hit: out_valid first high after edge E2.
- DONE:
  - out_valid and out_data are held stable until out_valid & out_ready.
  - On handoff: blk_count += 1; out_valid <= 0.
  - If in_valid is also high, the next request is accepted on the same edge (back-to-back); otherwise go to IDLE.
- in_ready = (state == IDLE) | (state == DONE & out_ready). It never depends on in_valid.
- Request inputs are sampled only on the accept edge; changes while busy are ignored.
- in_decrypt affects only subkey order. The key cache is shared between modes.
- blk_count wraps from 2^CNT_W-1 to 0 with no flag.
- rst_n = 0 on any edge, including mid-operation, sets:
  - state = IDLE; out_valid = 0; out_data = 0.
  - K1 = K2 = 0; cache_vld = 0; blk_count = 0; busy = 0.
  - A block in flight is discarded and no output is produced.
- Reset values of outputs: in_ready = 1 after reset (IDLE), busy = 0, out_valid = 0, out_data = 0x00, blk_count = 0.
- No X propagation: every register has a reset value.

Test Plan:
- Encrypt, fresh key: key 1010000010, data 10010111, decrypt = 0 -> K1 = 10100100, K2 = 01000011, out_data = 00111000; out_valid rises 3 edges after accept; blk_count = 1.
- Decrypt, same key (cache hit): data 00111000, decrypt = 1 -> out_data = 10010111; out_valid rises 2 edges after accept; KEY state never entered.
- Back-to-back: hold in_valid = 1 and out_ready = 1 with alternating keys 1010000010 / 0000000000 -> each result is accepted on its DONE edge; no idle cycles between blocks; results match a software model; blk_count counts every handoff.
- Backpressure: out_ready = 0 for 10 cycles in DONE -> out_data is stable; in_ready = 0; new in_valid is ignored; release -> a single handoff and a single count.
- Reset mid-block: deassert rst_n in R1 -> next cycle IDLE, out_valid = 0, cache_vld = 0; a re-sent identical key takes the KEY path (3-edge latency).
- Counter wrap with CNT_W = 4: 17 handoffs -> blk_count = 1.
- Random regression: 1000 random key/data/mode requests with random out_ready -> every result matches the reference model; each encrypt/decrypt pair round-trips.

Source files
------------

// File: rtl/sdes_block_ctrl.sv
// Iterative S-DES encrypt/decrypt engine. One feistel_round is reused for both
// rounds; the controller owns the key schedule, IP/IP^-1, half swap and subkey order.

module feistel_round (
   input  logic [7:0] data,
   input  logic [7:0] subkey,
   output logic [7:0] result
);
   localparam logic [1:0] S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                      2'd3, 2'd2, 2'd1, 2'd0,
                                      2'd0, 2'd2, 2'd1, 2'd3,
                                      2'd3, 2'd1, 2'd3, 2'd2};
   localparam logic [1:0] S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                      2'd2, 2'd0, 2'd1, 2'd3,
                                      2'd3, 2'd0, 2'd1, 2'd0,
                                      2'd2, 2'd1, 2'd0, 2'd3};

   logic [7:0] mixed;
   logic [1:0] s0_out;
   logic [1:0] s1_out;
   logic [3:0] f_out;

   // S-box index is {row, col}: row = outer bits, col = inner bits of each nibble
   always_comb begin
      mixed  = {data[0], data[3], data[2], data[1], data[2], data[1], data[0], data[3]} ^ subkey;
      s0_out = S0[{mixed[7], mixed[4], mixed[6], mixed[5]}];
      s1_out = S1[{mixed[3], mixed[0], mixed[2], mixed[1]}];
      f_out  = {s0_out[0], s1_out[0], s1_out[1], s0_out[1]};
      result = {data[7:4] ^ f_out, data[3:0]};
   end
endmodule

module sdes_block_ctrl #(
   parameter bit KEY_CACHE = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [9:0]       in_key,
   input  logic             in_decrypt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             busy,
   output logic [CNT_W-1:0] blk_count
);
   typedef enum logic [2:0] {IDLE, KEY, R1, R2, DONE} state_t;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] data_q;
   logic [9:0] key_q;
   logic       dec_q;
   logic [7:0] k1_q;
   logic [7:0] k2_q;
   logic [9:0] cache_key;
   logic       cache_vld;

   logic       accept;
   logic       handoff;
   logic       key_miss;
   logic [9:0] p10;
   logic [9:0] ls1;
   logic [9:0] ls2;
   logic [7:0] k1_w;
   logic [7:0] k2_w;
   logic [7:0] ip_in;
   logic [7:0] round_key;
   logic [7:0] round_out;
   logic [7:0] ipi_out;

   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;
   assign handoff  = out_valid & out_ready;
   assign busy     = (state_q != IDLE);
   assign key_miss = !KEY_CACHE || !cache_vld || (in_key != cache_key);

   // Subkeys are derived from the registered key so the KEY cycle only loads them
   always_comb begin
      p10  = {key_q[7], key_q[5], key_q[8], key_q[3], key_q[6],
              key_q[0], key_q[9], key_q[1], key_q[2], key_q[4]};
      ls1  = {p10[8:5], p10[9], p10[3:0], p10[4]};
      ls2  = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
      k1_w = {ls1[4], ls1[7], ls1[3], ls1[6], ls1[2], ls1[5], ls1[0], ls1[1]};
      k2_w = {ls2[4], ls2[7], ls2[3], ls2[6], ls2[2], ls2[5], ls2[0], ls2[1]};
      ip_in = {in_data[6], in_data[2], in_data[5], in_data[7],
               in_data[4], in_data[0], in_data[3], in_data[1]};
      if (state_q == R1) begin
         round_key = dec_q ? k2_q : k1_q;
      end else begin
         round_key = dec_q ? k1_q : k2_q;
      end
      ipi_out = {round_out[4], round_out[7], round_out[5], round_out[3],
                 round_out[1], round_out[6], round_out[0], round_out[2]};
   end

   feistel_round u_round (
      .data   (data_q),
      .subkey (round_key),
      .result (round_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = key_miss ? KEY : R1;
         KEY:  state_d = R1;
         R1:   state_d = R2;
         R2:   state_d = DONE;
         DONE: begin
            if (out_ready) begin
               if (accept) state_d = key_miss ? KEY : R1;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Accept happens only in IDLE/DONE, so it never collides with the R1 data update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q    <= '0;
         key_q     <= '0;
         dec_q     <= 1'b0;
         k1_q      <= '0;
         k2_q      <= '0;
         cache_key <= '0;
         cache_vld <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         blk_count <= '0;
      end else begin
         if (accept) begin
            data_q <= ip_in;
            key_q  <= in_key;
            dec_q  <= in_decrypt;
         end
         if (handoff) begin
            out_valid <= 1'b0;
            blk_count <= blk_count + CNT_W'(1);
         end
         case (state_q)
            KEY: begin
               k1_q      <= k1_w;
               k2_q      <= k2_w;
               cache_key <= key_q;
               cache_vld <= 1'b1;
            end
            R1: data_q <= {round_out[3:0], round_out[7:4]};
            R2: begin
               out_data  <= ipi_out;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sdes_block_ctrl.sv
// Self-checking bench for sdes_block_ctrl: constant/table vectors, corner sequences
// and a randomized stream scored against a table-driven S-DES reference model.

module tb_sdes_block_ctrl;
   localparam int TB_CNT_W = 4;
   localparam int CNT_MOD  = 1 << TB_CNT_W;
   localparam int N_RAND   = 1000;

   localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
   localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
   localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
   localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
   localparam int P4_T  [4]  = '{2, 4, 3, 1};
   localparam int SB0 [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
   localparam int SB1 [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};
   localparam logic [9:0] KEY_A = 10'b1010000010;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          in_data;
   logic [9:0]          in_key;
   logic                in_decrypt;
   logic                out_valid;
   logic                out_ready;
   logic [7:0]          out_data;
   logic                busy;
   logic [TB_CNT_W-1:0] blk_count;

   int         n_vec = 0;
   int         n_err = 0;
   int         m_count = 0;
   logic [9:0] m_cache_key = '0;
   logic       m_cache_vld = 1'b0;

   typedef struct {
      logic [9:0] key;
      logic [7:0] data;
      logic       dec;
      logic [7:0] exp_out;
      int         exp_lat;
   } vec_t;

   typedef struct {
      logic [9:0] key;
      logic [7:0] data;
      logic       dec;
      logic [7:0] exp_out;
   } req_t;

   sdes_block_ctrl #(.KEY_CACHE(1'b1), .CNT_W(TB_CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .blk_count  (blk_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: every permutation is applied from its position table
   function automatic logic [9:0] rol5x2(input logic [9:0] v, input int n);
      logic [4:0] l = v[9:5];
      logic [4:0] r = v[4:0];
      for (int i = 0; i < n; i++) begin
         l = {l[3:0], l[4]};
         r = {r[3:0], r[4]};
      end
      return {l, r};
   endfunction

   function automatic logic [7:0] p8(input logic [9:0] v);
      logic [7:0] o;
      for (int i = 0; i < 8; i++) o[7-i] = v[10-P8_T[i]];
      return o;
   endfunction

   function automatic logic [7:0] perm8(input logic [7:0] v, input bit inverse);
      logic [7:0] o;
      for (int i = 0; i < 8; i++) o[7-i] = v[8-(inverse ? IPI_T[i] : IP_T[i])];
      return o;
   endfunction

   function automatic logic [15:0] keySched(input logic [9:0] k);
      logic [9:0] p;
      logic [9:0] s1;
      for (int i = 0; i < 10; i++) p[9-i] = k[10-P10_T[i]];
      s1 = rol5x2(p, 1);
      return {p8(s1), p8(rol5x2(s1, 2))};
   endfunction

   function automatic logic [3:0] fFunc(input logic [3:0] r, input logic [7:0] sk);
      logic [7:0] e;
      logic [3:0] s;
      logic [3:0] o;
      for (int i = 0; i < 8; i++) e[7-i] = r[4-EP_T[i]];
      e = e ^ sk;
      s[3:2] = 2'(SB0[int'({e[7], e[4]})][int'({e[6], e[5]})]);
      s[1:0] = 2'(SB1[int'({e[3], e[0]})][int'({e[2], e[1]})]);
      for (int i = 0; i < 4; i++) o[3-i] = s[4-P4_T[i]];
      return o;
   endfunction

   function automatic logic [7:0] refSdes(input logic [7:0] d, input logic [9:0] k, input logic dec);
      logic [15:0] ks = keySched(k);
      logic [7:0]  first = dec ? ks[7:0] : ks[15:8];
      logic [7:0]  second = dec ? ks[15:8] : ks[7:0];
      logic [7:0]  t = perm8(d, 1'b0);
      t = {t[7:4] ^ fFunc(t[3:0], first), t[3:0]};
      t = {t[3:0], t[7:4]};
      t = {t[7:4] ^ fFunc(t[3:0], second), t[3:0]};
      return perm8(t, 1'b1);
   endfunction

   function automatic int modelLat(input logic [9:0] k);
      return (m_cache_vld && k == m_cache_key) ? 2 : 3;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives one request from a negedge and waits for out_valid; returns edges after accept
   task automatic applyStimulus(input logic [9:0] k, input logic [7:0] d, input logic dec, output int lat);
      in_key = k; in_data = d; in_decrypt = dec; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      in_key = 10'($urandom); in_data = 8'($urandom); in_decrypt = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
   endtask

   task automatic runBlock(input logic [9:0] k, input logic [7:0] d, input logic dec,
                           input logic [7:0] exp_out, input int exp_lat);
      int lat;
      out_ready = 1'b0;
      checkOutput("idle_in_ready", 32'(in_ready), 32'(1));
      applyStimulus(k, d, dec, lat);
      m_cache_key = k; m_cache_vld = 1'b1;
      checkOutput("latency", 32'(lat), 32'(exp_lat));
      checkOutput("out_data", 32'(out_data), 32'(exp_out));
      if (out_valid) m_count = (m_count + 1) % CNT_MOD;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      checkOutput("out_valid_clear", 32'(out_valid), 32'(0));
      checkOutput("blk_count", 32'(blk_count), 32'(m_count));
   endtask

   task automatic testReset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_key = '0; in_data = '0; in_decrypt = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_out_data", 32'(out_data), 32'(0));
      checkOutput("rst_blk_count", 32'(blk_count), 32'(0));
      rst_n = 1'b1;
      m_count = 0; m_cache_vld = 1'b0;
      @(negedge clk);
   endtask

   task automatic testTable();
      vec_t       vecs [8];
      logic [9:0] ck = '0;
      logic       cv = 1'b0;
      vecs[0] = '{KEY_A, 8'b10010111, 1'b0, 8'b00111000, 3};
      vecs[1] = '{KEY_A, 8'b00111000, 1'b1, 8'b10010111, 2};
      vecs[2] = '{10'h000, 8'h00, 1'b0, 8'h00, 0};
      vecs[3] = '{10'h000, 8'hFF, 1'b1, 8'h00, 0};
      vecs[4] = '{10'h3FF, 8'hA5, 1'b0, 8'h00, 0};
      vecs[5] = '{10'h3FF, 8'h5A, 1'b0, 8'h00, 0};
      vecs[6] = '{KEY_A, 8'h3C, 1'b1, 8'h00, 0};
      vecs[7] = '{10'h155, 8'h01, 1'b0, 8'h00, 0};
      for (int i = 0; i < 8; i++) begin
         if (i >= 2) begin
            vecs[i].exp_out = refSdes(vecs[i].data, vecs[i].key, vecs[i].dec);
            vecs[i].exp_lat = (cv && ck == vecs[i].key) ? 2 : 3;
         end
         ck = vecs[i].key; cv = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
         runBlock(vecs[i].key, vecs[i].data, vecs[i].dec, vecs[i].exp_out, vecs[i].exp_lat);
      end
   endtask

   task automatic testBackpressure();
      int         lat;
      int         exp_lat = modelLat(KEY_A);
      logic [7:0] exp_out = refSdes(8'hC3, KEY_A, 1'b0);
      out_ready = 1'b0;
      applyStimulus(KEY_A, 8'hC3, 1'b0, lat);
      m_cache_key = KEY_A; m_cache_vld = 1'b1;
      checkOutput("bp_latency", 32'(lat), 32'(exp_lat));
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_key = 10'($urandom); in_data = 8'($urandom);
         #1;
         checkOutput("bp_out_data", 32'(out_data), 32'(exp_out));
         checkOutput("bp_in_ready", 32'(in_ready), 32'(0));
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      m_count = (m_count + 1) % CNT_MOD;
      checkOutput("bp_valid_clear", 32'(out_valid), 32'(0));
      checkOutput("bp_single_count", 32'(blk_count), 32'(m_count));
      repeat (3) @(negedge clk);
      checkOutput("bp_idle_after", 32'(busy), 32'(0));
      checkOutput("bp_count_hold", 32'(blk_count), 32'(m_count));
   endtask

   task automatic testBackToBack();
      logic [7:0] exp_q [$];
      req_t       reqs [6];
      int         j_acc = 0;
      int         j_out = 0;
      int         gaps = 0;
      int         cyc = 0;
      bit         started = 1'b0;
      for (int i = 0; i < 6; i++) begin
         reqs[i].key = (i % 2 == 0) ? KEY_A : 10'h000;
         reqs[i].data = 8'($urandom);
         reqs[i].dec = 1'(i / 2);
         reqs[i].exp_out = refSdes(reqs[i].data, reqs[i].key, reqs[i].dec);
      end
      out_ready = 1'b1;
      while (j_out < 6 && cyc < 100) begin
         if (started && !busy) gaps++;
         if (j_acc < 6) begin
            in_valid = 1'b1; in_key = reqs[j_acc].key;
            in_data = reqs[j_acc].data; in_decrypt = reqs[j_acc].dec;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            checkOutput("b2b_data", 32'(out_data), 32'(exp_q.pop_front()));
            if (j_acc < 6) checkOutput("b2b_same_edge_accept", 32'(in_ready), 32'(1));
            j_out++;
            m_count = (m_count + 1) % CNT_MOD;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(reqs[j_acc].exp_out);
            m_cache_key = reqs[j_acc].key; m_cache_vld = 1'b1;
            j_acc++;
            started = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checkOutput("b2b_handoffs", 32'(j_out), 32'(6));
      checkOutput("b2b_idle_gaps", 32'(gaps), 32'(0));
      checkOutput("b2b_blk_count", 32'(blk_count), 32'(m_count));
   endtask

   task automatic testResetMidBlock();
      int any_valid = 0;
      runBlock(10'h2C7, 8'h11, 1'b0, refSdes(8'h11, 10'h2C7, 1'b0), modelLat(10'h2C7));
      in_key = 10'h2C7; in_data = 8'h22; in_decrypt = 1'b0; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      checkOutput("mid_busy_before", 32'(busy), 32'(1));
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      checkOutput("mid_busy", 32'(busy), 32'(0));
      checkOutput("mid_out_valid", 32'(out_valid), 32'(0));
      checkOutput("mid_in_ready", 32'(in_ready), 32'(1));
      checkOutput("mid_out_data", 32'(out_data), 32'(0));
      checkOutput("mid_blk_count", 32'(blk_count), 32'(0));
      rst_n = 1'b1;
      m_count = 0; m_cache_vld = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) any_valid++;
      end
      checkOutput("mid_no_output", 32'(any_valid), 32'(0));
      runBlock(10'h2C7, 8'h22, 1'b0, refSdes(8'h22, 10'h2C7, 1'b0), 3);
   endtask

   task automatic testWrap();
      for (int i = 0; i < 16; i++) begin
         logic [9:0] k = (i % 3 == 0) ? KEY_A : 10'($urandom);
         logic [7:0] d = 8'($urandom);
         logic       dec = 1'($urandom);
         runBlock(k, d, dec, refSdes(d, k, dec), modelLat(k));
      end
      checkOutput("wrap_count", 32'(blk_count), 32'(1));
   endtask

   task automatic testRandom();
      req_t       reqs [$];
      logic [7:0] exp_q [$];
      logic [9:0] pool [4] = '{KEY_A, 10'h000, 10'h3FF, 10'h155};
      int         ia = 0;
      int         io = 0;
      int         cyc = 0;
      for (int p = 0; p < N_RAND / 2; p++) begin
         logic [9:0] k = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : 10'($urandom);
         logic [7:0] d = 8'($urandom);
         logic       m = 1'($urandom);
         logic [7:0] c = refSdes(d, k, m);
         reqs.push_back('{k, d, m, c});
         reqs.push_back('{k, c, !m, d});
      end
      while (io < N_RAND && cyc < 40000) begin
         checkOutput("rand_blk_count", 32'(blk_count), 32'(m_count));
         out_ready = ($urandom_range(0, 2) != 0);
         if (ia < N_RAND && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1; in_key = reqs[ia].key;
            in_data = reqs[ia].data; in_decrypt = reqs[ia].dec;
         end else begin
            in_valid = 1'b0; in_key = 10'($urandom);
            in_data = 8'($urandom); in_decrypt = 1'($urandom);
         end
         #1;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("rand_spurious_valid", 32'(1), 32'(0));
            end else begin
               checkOutput("rand_out_data", 32'(out_data), 32'(exp_q[0]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  io++;
                  m_count = (m_count + 1) % CNT_MOD;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(reqs[ia].exp_out);
            ia++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checkOutput("rand_completed", 32'(io), 32'(N_RAND));
   endtask

   initial begin
      testReset();
      testTable();
      testBackpressure();
      testBackToBack();
      testResetMidBlock();
      testWrap();
      testRandom();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
